// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// Widths match the 32x32 register file; RF_NUM_REQ is the default
// number of write-back sources (ALU, load unit, multicycle unit).
package regfile_pkg;

  localparam int RF_AW      = 5;
  localparam int RF_DW      = 32;
  localparam int RF_NUM_REQ = 3;

  // One write-back request as seen from a single source.
  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter. Scans requesters from r_ptr upward (mod
// NUM_REQ) and grants the first valid one. The grant is purely a function
// of the valid vector and r_ptr, never of request payloads. r_ptr moves to
// one past the winner whenever a grant is issued, which bounds the wait of
// a continuously valid requester to NUM_REQ cycles.
//
// Handshake: a requester transfers in the cycle where its valid and its
// o_grant bit are both high; o_grant has at most one bit set.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;
  logic          w_any;

  // Priority scan starting at r_ptr; the one extra bit on w_sum covers the wrap.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_any   = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      w_cand = w_sum[IW-1:0];
      if (!w_any && i_valid[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        w_any           = 1'b1;
      end
    end
  end

  // Advance the rotating pointer past the winner; hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      if (o_idx == IW'(NUM_REQ - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= o_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file. NUM_REQ sources share
// the single write port through a round-robin arbiter (rr_arbiter); the
// winning write is registered and driven onto rf_waddr/rf_wdata/rf_wren
// one cycle after its handshake. fwd_hit0/1 flag read ports whose address
// matches the write landing this cycle, since the register file only
// commits it at the end of that cycle.
//
// Handshake: requester i transfers when req_valid[i] & req_ready[i];
// req_ready is one-hot or zero and depends only on req_valid.
//
// Optional build macro REG0_ZERO_EN: register 0 is hardwired zero. Writes
// to address 0 still complete their handshake but never assert rf_wren,
// and reads of address 0 never report a forwarding hit.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = RF_NUM_REQ,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic                  rf_wren,
  input  logic [AW-1:0]         raddr0,
  input  logic [AW-1:0]         raddr1,
  output logic                  fwd_hit0,
  output logic                  fwd_hit1,
  output logic [DW-1:0]         fwd_data
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_xfer;
  logic [AW-1:0]      w_addr_arr [NUM_REQ];
  logic [DW-1:0]      w_data_arr [NUM_REQ];
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_data;
  logic               w_wren_next;

  logic [AW-1:0]      r_waddr;
  logic [DW-1:0]      r_wdata;
  logic               r_wren;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .i_valid (req_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  // Unpack the per-requester address/data fields so the winner index can select them.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr_arr[i] = req_addr[i*AW +: AW];
      w_data_arr[i] = req_data[i*DW +: DW];
    end
  end

  // Winner payload and whether it produces a real register-file write.
  always_comb begin
    w_sel_addr = w_addr_arr[w_idx];
    w_sel_data = w_data_arr[w_idx];
`ifdef REG0_ZERO_EN
    w_wren_next = (w_sel_addr != '0);
`else
    w_wren_next = 1'b1;
`endif
  end

  // Output stage: capture the granted write; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wren  <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_xfer) begin
      r_wren  <= w_wren_next;
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
    end else begin
      r_wren  <= 1'b0;
    end
  end

  assign rf_wren  = r_wren;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign fwd_data = r_wdata;

  // Forwarding compare against the write that commits at the end of this cycle.
  always_comb begin
`ifdef REG0_ZERO_EN
    fwd_hit0 = r_wren && (raddr0 == r_waddr) && (raddr0 != '0);
    fwd_hit1 = r_wren && (raddr1 == r_waddr) && (raddr1 != '0);
`else
    fwd_hit0 = r_wren && (raddr0 == r_waddr);
    fwd_hit1 = r_wren && (raddr1 == r_waddr);
`endif
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge. A reference round-robin
// pointer predicts each grant; every predicted handshake pushes the write
// it should produce onto exp_q, which is popped one cycle later against
// the output stage and the forwarding flags. A register-file model
// commits the DUT writes so end results can be checked.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int QW      = 1 + AW + DW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [AW-1:0]         rf_waddr;
  logic [DW-1:0]         rf_wdata;
  logic                  rf_wren;
  logic [AW-1:0]         raddr0;
  logic [AW-1:0]         raddr1;
  logic                  fwd_hit0;
  logic                  fwd_hit1;
  logic [DW-1:0]         fwd_data;

  int errors = 0;
  int checks = 0;

  logic [QW-1:0]      exp_q[$];
  int                 m_ptr;
  logic [DW-1:0]      rf_model [32];
  logic [NUM_REQ-1:0] last_ready;
  logic               obs_wren;
  logic               obs_hit0;
  logic               obs_hit1;

  regfile_wb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_wren   (rf_wren),
    .raddr0    (raddr0),
    .raddr1    (raddr1),
    .fwd_hit0  (fwd_hit0),
    .fwd_hit1  (fwd_hit1),
    .fwd_data  (fwd_data)
  );

  // clock / register-file model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wren) rf_model[rf_waddr] <= rf_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid = (req_valid & ~(NUM_REQ'(1) << i)) | (NUM_REQ'(v) << i);
    req_addr  = (req_addr & ~((NUM_REQ*AW)'({AW{1'b1}}) << (i*AW)))
              | ((NUM_REQ*AW)'(a) << (i*AW));
    req_data  = (req_data & ~((NUM_REQ*DW)'({DW{1'b1}}) << (i*DW)))
              | ((NUM_REQ*DW)'(d) << (i*DW));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    raddr0    = '0;
    raddr1    = '0;
    exp_q.delete();
    m_ptr     = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle with scoreboard checks on the falling edge.
  task automatic step(input string tag);
    logic [QW-1:0]      e;
    logic               e_wren;
    logic [AW-1:0]      e_addr;
    logic [DW-1:0]      e_data;
    logic               h0;
    logic               h1;
    logic [NUM_REQ-1:0] g;
    int                 win;
    int                 j;
    logic [AW-1:0]      a;
    logic [DW-1:0]      d;
    logic               w;
    @(negedge clk);
    obs_wren = rf_wren;
    obs_hit0 = fwd_hit0;
    obs_hit1 = fwd_hit1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
    {e_wren, e_addr, e_data} = e;

    checks++;
    if (rf_wren !== e_wren) begin
      errors++;
      $display("FAIL %s rf_wren: got %0b expected %0b", tag, rf_wren, e_wren);
    end
    if (e_wren) begin
      checks++;
      if (rf_waddr !== e_addr || rf_wdata !== e_data || fwd_data !== e_data) begin
        errors++;
        $display("FAIL %s write: got addr=%0d data=%h fwd=%h expected addr=%0d data=%h",
                 tag, rf_waddr, rf_wdata, fwd_data, e_addr, e_data);
      end
    end

    h0 = e_wren && (raddr0 == e_addr);
    h1 = e_wren && (raddr1 == e_addr);
`ifdef REG0_ZERO_EN
    h0 = h0 && (raddr0 != '0);
    h1 = h1 && (raddr1 != '0);
`endif
    checks++;
    if (fwd_hit0 !== h0 || fwd_hit1 !== h1) begin
      errors++;
      $display("FAIL %s fwd_hit: got %0b%0b expected %0b%0b", tag, fwd_hit0, fwd_hit1, h0, h1);
    end

    g   = '0;
    win = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (m_ptr + k) % NUM_REQ;
      if (g == '0 && ((req_valid >> j) & NUM_REQ'(1)) != '0) begin
        g   = NUM_REQ'(1) << j;
        win = j;
      end
    end
    checks++;
    if (req_ready !== g) begin
      errors++;
      $display("FAIL %s req_ready: got %b expected %b", tag, req_ready, g);
    end
    last_ready = req_ready;
    if (g != '0) begin
      a = AW'(req_addr >> (win*AW));
      d = DW'(req_data >> (win*DW));
      w = 1'b1;
`ifdef REG0_ZERO_EN
      w = (a != '0);
`endif
      exp_q.push_back({w, a, d});
      m_ptr = (win + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    raddr0    = '0;
    raddr1    = '0;
    #2;
    checks++;
    if (rf_wren !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      errors++;
      $display("FAIL reset outputs: got wren=%0b addr=%0d data=%h expected 0/0/0",
               rf_wren, rf_waddr, rf_wdata);
    end
    checks++;
    if (fwd_hit0 !== 1'b0 || fwd_hit1 !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset flags: got hit=%0b%0b ready=%b expected 00/000",
               fwd_hit0, fwd_hit1, req_ready);
    end
    req_valid = 3'b110;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL reset grant: got %b expected 010", req_ready);
    end
    do_reset();
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    step("single_hs");
    checks++;
    if (last_ready !== 3'b001) begin
      errors++;
      $display("FAIL single grant: got %b expected 001", last_ready);
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    step("single_wr");
    step("single_idle");
    checks++;
    if (obs_wren !== 1'b0) begin
      errors++;
      $display("FAIL single idle wren: got %0b expected 0", obs_wren);
    end
  endtask

  task automatic test_all_valid();
    logic [11:0] seq;
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h1111_0000);
    set_req(1, 1'b1, 5'd2, 32'h2222_0000);
    set_req(2, 1'b1, 5'd3, 32'h3333_0000);
    seq = 12'b001_100_010_001;
    for (int k = 0; k < 4; k++) begin
      step("all_valid");
      checks++;
      if (last_ready !== seq[2:0]) begin
        errors++;
        $display("FAIL all_valid grant %0d: got %b expected %b", k, last_ready, seq[2:0]);
      end
      seq = seq >> 3;
    end
    for (int k = 0; k < 3; k++) step("all_valid_more");
    req_valid = '0;
    step("all_valid_drain");
  endtask

  task automatic test_collision();
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'd1);
    set_req(1, 1'b1, 5'd7, 32'd2);
    step("coll_0");
    set_req(0, 1'b0, 5'd0, 32'd0);
    step("coll_1");
    set_req(1, 1'b0, 5'd0, 32'd0);
    step("coll_2");
    step("coll_3");
    checks++;
    if (rf_model[7] !== 32'd2) begin
      errors++;
      $display("FAIL collision reg7: got %h expected 2", rf_model[7]);
    end
  endtask

  task automatic test_forward();
    set_req(2, 1'b1, 5'd9, 32'h55);
    raddr0 = 5'd9;
    raddr1 = 5'd3;
    step("fwd_hs");
    set_req(2, 1'b0, 5'd0, 32'h0);
    step("fwd_hit");
    checks++;
    if (obs_hit0 !== 1'b1 || obs_hit1 !== 1'b0) begin
      errors++;
      $display("FAIL forward flags: got %0b%0b expected 10", obs_hit0, obs_hit1);
    end
    raddr0 = '0;
    raddr1 = '0;
    step("fwd_idle");
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] old12;
    do_reset();
    old12 = rf_model[12];
    set_req(1, 1'b1, 5'd12, 32'h1234);
    set_req(2, 1'b1, 5'd13, 32'h5678);
    step("mid_hs");
    checks++;
    if (rf_wren !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset pre wren: got %0b expected 1", rf_wren);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rf_wren !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset async wren: got %0b expected 0", rf_wren);
    end
    exp_q.delete();
    m_ptr = 0;
    set_req(1, 1'b1, 5'd12, 32'h1234);
    @(posedge clk);
    #1;
    checks++;
    if (rf_model[12] !== old12) begin
      errors++;
      $display("FAIL mid_reset discarded write: got %h expected %h", rf_model[12], old12);
    end
    rst = 1'b0;
    step("mid_after");
    checks++;
    if (last_ready !== 3'b010) begin
      errors++;
      $display("FAIL mid_reset first grant: got %b expected 010", last_ready);
    end
    req_valid = '0;
    step("mid_drain_a");
    step("mid_drain_b");
  endtask

  task automatic test_reg0();
    set_req(0, 1'b1, 5'd0, 32'hFFFF);
    raddr0 = 5'd0;
    raddr1 = 5'd4;
    step("reg0_hs");
    checks++;
    if (last_ready === '0) begin
      errors++;
      $display("FAIL reg0 handshake: got ready=%b expected nonzero", last_ready);
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    step("reg0_wr");
    checks++;
`ifdef REG0_ZERO_EN
    if (obs_wren !== 1'b0 || obs_hit0 !== 1'b0) begin
      errors++;
      $display("FAIL reg0 suppressed: got wren=%0b hit0=%0b expected 0/0", obs_wren, obs_hit0);
    end
`else
    if (obs_wren !== 1'b1 || obs_hit0 !== 1'b1) begin
      errors++;
      $display("FAIL reg0 ordinary: got wren=%0b hit0=%0b expected 1/1", obs_wren, obs_hit0);
    end
`endif
    raddr1 = '0;
    step("reg0_idle");
  endtask

  task automatic test_back_to_back();
    do_reset();
    last_ready = '0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (((last_ready >> i) & NUM_REQ'(1)) != '0 || ((req_valid >> i) & NUM_REQ'(1)) == '0) begin
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom());
        end
      end
      raddr0 = AW'($urandom_range(0, 31));
      raddr1 = AW'($urandom_range(0, 31));
      step("random");
    end
    req_valid = '0;
    step("random_drain");
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_collision();
    test_forward();
    test_mid_reset();
    test_reg0();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
